// File: rtl/rv_muldiv_unit_pkg.sv
// rtl/rv_muldiv_unit_pkg.sv - funct3 encodings, FSM states and op decode helpers for the M-extension unit
package rv_muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_PREP,
    S_DIV_ITER,
    S_DIV_FIX,
    S_DONE
  } md_state_t;

  function automatic logic is_div_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_mul_high(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - radix-2 restoring divider datapath, one quotient bit per step
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_diff_bit;

  // The dividend is shifted out of the quotient register MSB-first while quotient bits enter at the LSB.
  assign shifted         = {remainder, quotient[XLEN-1]};
  assign diff            = {1'b0, shifted} - {2'b00, dvsr};
  assign last            = (cnt == '0);
  assign unused_diff_bit = diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
      cnt       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
      cnt       <= CW'(XLEN - 1);
    end else if (step) begin
      remainder <= diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], ~diff[XLEN+1]};
      cnt       <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU
module rv_muldiv_unit
  import rv_muldiv_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] done_tag
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam int              PW       = 2 * XLEN + 2;

  md_state_t        state;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN:0]    ma_q, mb_q;
  logic             q_neg, r_neg;
  logic [2:0]       mcnt;

  logic accept, div_zero, div_ovf, a_sx, b_sx;

  always_comb begin
    accept   = start && !busy && !flush && (state == S_IDLE);
    div_zero = (rs2 == '0);
    div_ovf  = is_signed_div(funct3) && (rs1 == MOST_NEG) && (rs2 == '1);
    a_sx     = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    b_sx     = (funct3 == F3_MULH);
  end

  // One signed XLEN+1 by XLEN+1 multiplier covers all four multiply flavours.
  logic signed [PW-1:0] pa, pb;
  logic [PW-1:0]        prod, mul_tap;
  logic [XLEN-1:0]      mul_res;
  logic                 unused_mul_msbs;

  assign pa              = {{(XLEN+1){ma_q[XLEN]}}, ma_q};
  assign pb              = {{(XLEN+1){mb_q[XLEN]}}, mb_q};
  assign prod            = pa * pb;
  assign mul_res         = is_mul_high(f3_q) ? mul_tap[2*XLEN-1:XLEN] : mul_tap[XLEN-1:0];
  assign unused_mul_msbs = ^mul_tap[PW-1:2*XLEN];

  if (MUL_LATENCY == 1) begin : g_no_chain
    assign mul_tap = prod;
  end else begin : g_chain
    logic [PW-1:0] stage [MUL_LATENCY-1];
    always_ff @(posedge clk) begin
      stage[0] <= prod;
      for (int i = 1; i < MUL_LATENCY - 1; i++) stage[i] <= stage[i-1];
    end
    assign mul_tap = stage[MUL_LATENCY-2];
  end

  logic            sd_q, div_last;
  logic [XLEN-1:0] a_abs, b_abs, quo, rem, quo_fix, rem_fix, spec_res;

  always_comb begin
    sd_q    = is_signed_div(f3_q);
    a_abs   = (sd_q && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs   = (sd_q && b_q[XLEN-1]) ? -b_q : b_q;
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -rem : rem;
    // Only divide-by-zero and signed overflow ever reach S_DONE.
    if (b_q == '0) spec_res = is_rem_op(f3_q) ? a_q : '1;
    else           spec_res = is_rem_op(f3_q) ? '0  : a_q;
  end

  muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (state == S_DIV_PREP),
    .step      (state == S_DIV_ITER),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      done_tag <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      mcnt     <= '0;
    end else begin
      done <= 1'b0;
      // busy stays up through the done cycle so a held start is taken only afterwards.
      if (done) busy <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          busy  <= 1'b1;
          f3_q  <= funct3;
          a_q   <= rs1;
          b_q   <= rs2;
          tag_q <= rd_tag;
          ma_q  <= {a_sx & rs1[XLEN-1], rs1};
          mb_q  <= {b_sx & rs2[XLEN-1], rs2};
          mcnt  <= '0;
          if (!is_div_op(funct3))      state <= S_MUL;
          else if (div_zero || div_ovf) state <= S_DONE;
          else                          state <= S_DIV_PREP;
        end
      end else if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_MUL: begin
            if (mcnt == 3'(MUL_LATENCY - 1)) begin
              done     <= 1'b1;
              result   <= mul_res;
              done_tag <= tag_q;
              state    <= S_IDLE;
            end else begin
              mcnt <= mcnt + 3'd1;
            end
          end
          S_DIV_PREP: begin
            q_neg <= sd_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
            r_neg <= sd_q && a_q[XLEN-1];
            state <= S_DIV_ITER;
          end
          S_DIV_ITER: begin
            if (div_last) state <= S_DIV_FIX;
          end
          S_DIV_FIX: begin
            done     <= 1'b1;
            result   <= is_rem_op(f3_q) ? rem_fix : quo_fix;
            done_tag <= tag_q;
            state    <= S_IDLE;
          end
          S_DONE: begin
            done     <= 1'b1;
            result   <= spec_res;
            done_tag <= tag_q;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - self-checking bench for rv_muldiv_unit against an arithmetic reference model
module tb_rv_muldiv_unit;
  localparam int XLEN = 32;
  localparam int MUL_LATENCY = 2;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst, start, flush;
  logic [2:0] funct3;
  logic [XLEN-1:0] rs1, rs2;
  logic [TAG_W-1:0] rd_tag;
  logic busy, done;
  logic [XLEN-1:0] result;
  logic [TAG_W-1:0] done_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .rd_tag(rd_tag), .flush(flush), .busy(busy), .done(done), .result(result),
    .done_tag(done_tag)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0] w;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0;
    case (f3)
      3'd0: begin sp = sa * sb; w = sp; r = w[31:0]; end
      3'd1: begin sp = sa * sb; w = sp; r = w[63:32]; end
      3'd2: begin sp = sa * longint'(ub); w = sp; r = w[63:32]; end
      3'd3: begin up = ua * ub; w = up; r = w[63:32]; end
      3'd4: if (b == 0) r = '1; else begin sp = sa / sb; w = sp; r = w[31:0]; end
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a; else begin sp = sa % sb; w = sp; r = w[31:0]; end
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LATENCY;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
    return XLEN + 2;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output int lat, output logic [31:0] res,
                       output logic [4:0] tg);
    int n;
    bit got;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    funct3 = f3; rs1 = a; rs2 = b; rd_tag = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_tag = 5'($urandom);
    lat = 0; got = 0; res = 'x; tg = 'x;
    while (!got && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1) begin got = 1; res = result; tg = done_tag; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (done_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", done_tag); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat;
    logic [31:0] r;
    logic [4:0] tg;
    v.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
    v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
    v.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2});
    v.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34});
    v.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34});
    v.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 34});
    v.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34});
    v.push_back('{3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1});
    v.push_back('{3'd6, 32'd100, 32'd0, 32'd100, 1});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].a, v[i].b, 5'(i + 3), lat, r, tg);
      checks++;
      if (r !== v[i].exp) begin
        errors++; $display("FAIL dir_result[%0d]: got %h want %h", i, r, v[i].exp);
      end
      checks++;
      if (lat != v[i].lat) begin
        errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, v[i].lat);
      end
      checks++;
      if (tg !== 5'(i + 3)) begin
        errors++; $display("FAIL dir_tag[%0d]: got %h want %h", i, tg, 5'(i + 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r, a, b;
    logic [4:0] tg;
    logic [2:0] f3;
    for (int i = 0; i < 4; i++) begin
      f3 = (i % 2 == 0) ? 3'd0 : 3'd5;
      a = $urandom; b = $urandom_range(1, 1000);
      do_op(f3, a, b, 5'(i), lat, r, tg);
      checks++;
      if (r !== model(f3, a, b)) begin
        errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, r, model(f3, a, b));
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_in_done[%0d]: got %b want 1", i, busy); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after[%0d]: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, b, r;
    logic [4:0] t, tg;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        3: b = 32'($urandom_range(0, 3)) - 32'd1;
        default: ;
      endcase
      t = 5'($urandom);
      do_op(f3, a, b, t, lat, r, tg);
      checks++;
      if (r !== model(f3, a, b)) begin
        errors++; $display("FAIL rnd_result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, r, model(f3, a, b));
      end
      checks++;
      if (lat != model_lat(f3, a, b)) begin
        errors++; $display("FAIL rnd_latency f3=%0d a=%h b=%h: got %0d want %0d", f3, a, b, lat, model_lat(f3, a, b));
      end
      checks++;
      if (tg !== t) begin errors++; $display("FAIL rnd_tag: got %h want %h", tg, t); end
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] r, prev;
    logic [4:0] tg;
    bit saw_done, changed;
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd1, lat, r, tg);
    prev = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    checks++;
    if (r !== prev) begin errors++; $display("FAIL flush_setup: got %h want %h", r, prev); end
    @(posedge clk); #1;
    // flush ten cycles into a divide
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_tag = 5'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    saw_done = 0; changed = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1;
      if (result !== prev) changed = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL flush_no_done: got 1 want 0"); end
    checks++;
    if (changed) begin errors++; $display("FAIL flush_result_held: got %h want %h", result, prev); end
    do_op(3'd5, 32'd1000, 32'd7, 5'd10, lat, r, tg);
    checks++;
    if (r !== 32'd142 || lat != 34 || tg !== 5'd10) begin
      errors++; $display("FAIL flush_next_op: got %h lat %0d tag %h want 0000008e lat 34 tag 0a", r, lat, tg);
    end
    // start and flush together: start is rejected
    @(posedge clk); #1;
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL flush_start_no_done: got 1 want 0"); end
    // flush lands in the special-case DONE state: done suppressed
    funct3 = 3'd5; rs1 = 32'd55; rs2 = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_in_done: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (result !== 32'd142) begin errors++; $display("FAIL flush_in_done_result: got %h want 0000008e", result); end
  endtask

  task automatic test_busy_start();
    int lat;
    bit got, extra;
    logic [31:0] r;
    logic [4:0] tg;
    funct3 = 3'd4; rs1 = 32'hFFFF_FFEC; rs2 = 32'd3; rd_tag = 5'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0; got = 0; r = 'x; tg = 'x;
    while (!got && lat < 100) begin
      if (lat == 5) begin funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_tag = 5'd17; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1; lat++;
      if (done === 1'b1) begin got = 1; r = result; tg = done_tag; end
    end
    start = 1'b0;
    checks++;
    if (r !== 32'hFFFF_FFFA) begin errors++; $display("FAIL busy_start_result: got %h want fffffffa", r); end
    checks++;
    if (tg !== 5'd5) begin errors++; $display("FAIL busy_start_tag: got %h want 05", tg); end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done === 1'b1) extra = 1; end
    checks++;
    if (extra || busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored: got extra=%b busy=%b want 0 0", extra, busy); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_tag = 5'd12; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL reset_mid_no_done: got 1 want 0"); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_tag = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
